// File: rtl/ysyx_22050550_pkg.sv
// Shared definitions for the ysyx_22050550 SRAM AXI slave: FSM encoding,
// AXI response codes and the beat byte stride.
package ysyx_22050550_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RREQ  = 3'd1,
        ST_RDATA = 3'd2,
        ST_WDATA = 3'd3,
        ST_BRESP = 3'd4
    } state_e;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam int unsigned BEAT_BYTES  = 8;

endpackage

// File: rtl/ysyx_22050550_sram_axi_slave.sv
// AXI slave front-end for a single-port synchronous SRAM; one burst in flight,
// write requests take priority over reads when both arrive in IDLE.
module ysyx_22050550_sram_axi_slave
    import ysyx_22050550_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                io_sram_Axi_ar_valid,
    output logic                io_sram_Axi_ar_ready,
    input  logic [ADDR_W-1:0]   io_sram_Axi_ar_bits_addr,
    input  logic [7:0]          io_sram_Axi_ar_bits_len,

    output logic                io_sram_Axi_r_valid,
    input  logic                io_sram_Axi_r_ready,
    output logic [DATA_W-1:0]   io_sram_Axi_r_bits_data,
    output logic                io_sram_Axi_r_bits_last,
    output logic [1:0]          io_sram_Axi_r_bits_resp,

    input  logic                io_sram_Axi_aw_valid,
    output logic                io_sram_Axi_aw_ready,
    input  logic [ADDR_W-1:0]   io_sram_Axi_aw_bits_addr,
    input  logic [7:0]          io_sram_Axi_aw_bits_len,

    input  logic                io_sram_Axi_w_valid,
    output logic                io_sram_Axi_w_ready,
    input  logic [DATA_W-1:0]   io_sram_Axi_w_bits_data,
    input  logic [DATA_W/8-1:0] io_sram_Axi_w_bits_strb,
    input  logic                io_sram_Axi_w_bits_last,

    output logic                io_sram_Axi_b_valid,
    input  logic                io_sram_Axi_b_ready,
    output logic [1:0]          io_sram_Axi_b_bits_resp,

    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(BEAT_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BEAT_BYTES - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [7:0]          cnt_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                rd_fresh_q;
    logic                err_q;

    logic ar_fire, aw_fire, r_fire, w_fire, b_fire, beat_last;

    assign ar_fire   = io_sram_Axi_ar_valid & io_sram_Axi_ar_ready;
    assign aw_fire   = io_sram_Axi_aw_valid & io_sram_Axi_aw_ready;
    assign r_fire    = io_sram_Axi_r_valid  & io_sram_Axi_r_ready;
    assign w_fire    = io_sram_Axi_w_valid  & io_sram_Axi_w_ready;
    assign b_fire    = io_sram_Axi_b_valid  & io_sram_Axi_b_ready;
    assign beat_last = (cnt_q == len_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (aw_fire) begin
                    state_d = ST_WDATA;
                end else if (ar_fire) begin
                    state_d = ST_RREQ;
                end
            end
            ST_RREQ:  state_d = ST_RDATA;
            ST_RDATA: begin
                if (r_fire) begin
                    state_d = beat_last ? ST_IDLE : ST_RREQ;
                end
            end
            ST_WDATA: begin
                if (w_fire && beat_last) begin
                    state_d = ST_BRESP;
                end
            end
            ST_BRESP: begin
                if (b_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        io_sram_Axi_aw_ready = 1'b0;
        io_sram_Axi_ar_ready = 1'b0;
        io_sram_Axi_r_valid  = 1'b0;
        io_sram_Axi_w_ready  = 1'b0;
        io_sram_Axi_b_valid  = 1'b0;
        mem_en               = 1'b0;
        mem_we               = 1'b0;
        mem_wdata            = '0;
        mem_wmask            = '0;
        case (state_q)
            ST_IDLE: begin
                io_sram_Axi_aw_ready = 1'b1;
                io_sram_Axi_ar_ready = ~io_sram_Axi_aw_valid;
            end
            ST_RREQ: begin
                mem_en = 1'b1;
            end
            ST_RDATA: begin
                io_sram_Axi_r_valid = 1'b1;
            end
            ST_WDATA: begin
                io_sram_Axi_w_ready = 1'b1;
                if (io_sram_Axi_w_valid) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = io_sram_Axi_w_bits_data;
                    mem_wmask = io_sram_Axi_w_bits_strb;
                end
            end
            ST_BRESP: begin
                io_sram_Axi_b_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_addr                = addr_q;
    // First RDATA cycle forwards the SRAM output while it is captured; later
    // stall cycles replay the captured copy so r data stays stable.
    assign io_sram_Axi_r_bits_data = rd_fresh_q ? mem_rdata : rdata_q;
    assign io_sram_Axi_r_bits_last = (state_q == ST_RDATA) && beat_last;
    assign io_sram_Axi_r_bits_resp = RESP_OKAY;
    assign io_sram_Axi_b_bits_resp = err_q ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            rd_fresh_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (aw_fire) begin
                        addr_q <= io_sram_Axi_aw_bits_addr & ALIGN_MASK;
                        len_q  <= io_sram_Axi_aw_bits_len;
                        cnt_q  <= '0;
                        err_q  <= 1'b0;
                    end else if (ar_fire) begin
                        addr_q <= io_sram_Axi_ar_bits_addr & ALIGN_MASK;
                        len_q  <= io_sram_Axi_ar_bits_len;
                        cnt_q  <= '0;
                    end
                end
                ST_RREQ: begin
                    rd_fresh_q <= 1'b1;
                end
                ST_RDATA: begin
                    if (rd_fresh_q) begin
                        rdata_q    <= mem_rdata;
                        rd_fresh_q <= 1'b0;
                    end
                    if (r_fire && !beat_last) begin
                        addr_q <= addr_q + STRIDE;
                        cnt_q  <= cnt_q + 8'd1;
                    end
                end
                ST_WDATA: begin
                    if (w_fire) begin
                        addr_q <= addr_q + STRIDE;
                        cnt_q  <= cnt_q + 8'd1;
                        if (io_sram_Axi_w_bits_last != beat_last) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050550_sram_axi_slave.sv
// Scoreboard bench for the SRAM AXI slave: stimulus pushes expected memory
// accesses and AXI responses, a negedge monitor pops and compares them.
module tb_ysyx_22050550_sram_axi_slave;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ar_valid = 1'b0, ar_ready;
    logic [63:0] ar_addr = '0;
    logic [7:0]  ar_len = '0;
    logic        r_valid, r_ready = 1'b0, r_last;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        aw_valid = 1'b0, aw_ready;
    logic [63:0] aw_addr = '0;
    logic [7:0]  aw_len = '0;
    logic        w_valid = 1'b0, w_ready, w_last = 1'b0;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        b_valid, b_ready = 1'b1;
    logic [1:0]  b_resp;
    logic        mem_en, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [7:0]  mem_wmask;

    ysyx_22050550_sram_axi_slave #(.ADDR_W(64), .DATA_W(64)) dut (
        .clock(clock), .reset(reset),
        .io_sram_Axi_ar_valid(ar_valid), .io_sram_Axi_ar_ready(ar_ready),
        .io_sram_Axi_ar_bits_addr(ar_addr), .io_sram_Axi_ar_bits_len(ar_len),
        .io_sram_Axi_r_valid(r_valid), .io_sram_Axi_r_ready(r_ready),
        .io_sram_Axi_r_bits_data(r_data), .io_sram_Axi_r_bits_last(r_last),
        .io_sram_Axi_r_bits_resp(r_resp),
        .io_sram_Axi_aw_valid(aw_valid), .io_sram_Axi_aw_ready(aw_ready),
        .io_sram_Axi_aw_bits_addr(aw_addr), .io_sram_Axi_aw_bits_len(aw_len),
        .io_sram_Axi_w_valid(w_valid), .io_sram_Axi_w_ready(w_ready),
        .io_sram_Axi_w_bits_data(w_data), .io_sram_Axi_w_bits_strb(w_strb),
        .io_sram_Axi_w_bits_last(w_last),
        .io_sram_Axi_b_valid(b_valid), .io_sram_Axi_b_ready(b_ready),
        .io_sram_Axi_b_bits_resp(b_resp),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ev_cyc = 0;
    int ar_hs_cyc = 0;
    int b_hs_cyc = 0;
    logic r_pending = 1'b0;

    typedef struct { logic [63:0] data; logic last; } rbeat_t;
    typedef struct { logic [63:0] addr; logic [63:0] data; logic [7:0] mask; } wr_t;
    rbeat_t      rq[$];
    logic [63:0] raddr_q[$];
    wr_t         wq[$];
    logic [1:0]  bq[$];

    logic [63:0] mem [logic [63:0]];

    function automatic logic [63:0] pat(input logic [63:0] a);
        return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0]};
    endfunction

    function automatic logic [63:0] rd_mem(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : pat(a);
    endfunction

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_en && !mem_we) begin
            mem_rdata <= rd_mem(mem_addr);
        end
        if (mem_en && mem_we) begin
            logic [63:0] cur;
            cur = rd_mem(mem_addr);
            for (int i = 0; i < 8; i++) begin
                if (mem_wmask[i]) cur[i*8 +: 8] = mem_wdata[i*8 +: 8];
            end
            mem[mem_addr] = cur;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic stray(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected activity at cycle %0d", name, cyc);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            r_pending = 1'b0;
        end else begin
            if (mem_en) begin
                if (mem_we) begin
                    if (wq.size() == 0) stray("stray_write");
                    else begin
                        wr_t w;
                        w = wq.pop_front();
                        chk("wr_addr", mem_addr, w.addr);
                        chk("wr_data", mem_wdata, w.data);
                        chk("wr_mask", {56'd0, mem_wmask}, {56'd0, w.mask});
                    end
                end else begin
                    if (raddr_q.size() == 0) stray("stray_read");
                    else begin
                        chk("rd_addr", mem_addr, raddr_q.pop_front());
                        chk("rd_issue_lat", 64'(cyc - ev_cyc), 64'd1);
                    end
                end
            end
            if (r_valid) begin
                if (!r_pending) begin
                    chk("r_latency", 64'(cyc - ev_cyc), 64'd2);
                    r_pending = 1'b1;
                end
                if (rq.size() == 0) stray("stray_r_beat");
                else begin
                    chk("r_data", r_data, rq[0].data);
                    chk("r_last", {63'd0, r_last}, {63'd0, rq[0].last});
                    chk("r_resp", {62'd0, r_resp}, 64'd0);
                    if (r_ready) begin
                        void'(rq.pop_front());
                        r_pending = 1'b0;
                        ev_cyc = cyc;
                    end
                end
            end
            if (ar_valid && ar_ready) begin
                ev_cyc = cyc;
                ar_hs_cyc = cyc;
            end
            if (b_valid) begin
                if (bq.size() == 0) stray("stray_b");
                else if (b_ready) begin
                    chk("b_resp", {62'd0, b_resp}, {62'd0, bq.pop_front()});
                    b_hs_cyc = cyc;
                end
            end
        end
    end

    task automatic exp_read(input logic [63:0] base, input int len);
        for (int i = 0; i <= len; i++) begin
            logic [63:0] a;
            rbeat_t rb;
            a = base + 64'(8 * i);
            raddr_q.push_back(a);
            rb.data = pat(a);
            rb.last = (i == len);
            rq.push_back(rb);
        end
    endtask

    task automatic exp_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
        wr_t w;
        w.addr = a; w.data = d; w.mask = m;
        wq.push_back(w);
    endtask

    task automatic ar_req(input logic [63:0] a, input logic [7:0] l);
        @(posedge clock); #1;
        ar_valid = 1'b1; ar_addr = a; ar_len = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (ar_ready) break;
            if (t == 199) stray("ar_timeout");
        end
        @(posedge clock); #1;
        ar_valid = 1'b0;
    endtask

    task automatic aw_req(input logic [63:0] a, input logic [7:0] l);
        @(posedge clock); #1;
        aw_valid = 1'b1; aw_addr = a; aw_len = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (aw_ready) break;
            if (t == 199) stray("aw_timeout");
        end
        @(posedge clock); #1;
        aw_valid = 1'b0;
    endtask

    task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
        @(posedge clock); #1;
        w_valid = 1'b1; w_data = d; w_strb = s; w_last = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (w_ready) break;
            if (t == 199) stray("w_timeout");
        end
        @(posedge clock); #1;
        w_valid = 1'b0; w_last = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int t = 0; t <= budget; t++) begin
            @(posedge clock);
            if (rq.size() == 0 && raddr_q.size() == 0 && wq.size() == 0 && bq.size() == 0) break;
            if (t == budget) begin
                stray("drain_timeout");
                rq.delete(); raddr_q.delete(); wq.delete(); bq.delete();
            end
        end
        #1;
    endtask

    task automatic wait_rvalid();
        for (int t = 0; t < 50; t++) begin
            @(negedge clock);
            if (r_valid) break;
            if (t == 49) stray("r_valid_timeout");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_r_valid", {63'd0, r_valid}, 64'd0);
        chk("rst_b_valid", {63'd0, b_valid}, 64'd0);
        chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_r_last", {63'd0, r_last}, 64'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_aw_ready", {63'd0, aw_ready}, 64'd1);
        chk("idle_ar_ready", {63'd0, ar_ready}, 64'd1);

        // single beat, unaligned address
        r_ready = 1'b1;
        exp_read(64'h8000_0000, 0);
        ar_req(64'h8000_0004, 8'd0);
        drain(50);

        // 4-beat read, first beat stalled 5 cycles
        r_ready = 1'b0;
        exp_read(64'h8000_0000, 3);
        ar_req(64'h8000_0000, 8'd3);
        wait_rvalid();
        repeat (5) @(posedge clock);
        #1 r_ready = 1'b1;
        drain(100);

        // write burst with partial strobe, then read it back
        exp_write(64'h100, 64'h1111_2222_3333_4444, 8'hFF);
        exp_write(64'h108, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
        bq.push_back(2'b00);
        aw_req(64'h100, 8'd1);
        w_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b0);
        w_beat(64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 1'b1);
        drain(50);
        begin
            rbeat_t rb;
            logic [63:0] p;
            p = pat(64'h108);
            raddr_q.push_back(64'h100);
            raddr_q.push_back(64'h108);
            rb.data = 64'h1111_2222_3333_4444; rb.last = 1'b0; rq.push_back(rb);
            rb.data = {p[63:32], 32'hCCCC_DDDD}; rb.last = 1'b1; rq.push_back(rb);
        end
        ar_req(64'h100, 8'd1);
        drain(50);

        // early w_last: burst still runs 2 beats, SLVERR
        exp_write(64'h200, 64'h0123_4567_89AB_CDEF, 8'hFF);
        exp_write(64'h208, 64'hFEDC_BA98_7654_3210, 8'hFF);
        bq.push_back(2'b10);
        aw_req(64'h203, 8'd1);
        w_beat(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
        w_beat(64'hFEDC_BA98_7654_3210, 8'hFF, 1'b1);
        drain(50);

        // simultaneous aw/ar: write wins, read follows the b handshake
        exp_write(64'h300, 64'h5555_6666_7777_8888, 8'hF0);
        bq.push_back(2'b00);
        exp_read(64'h8000_0100, 0);
        @(posedge clock); #1;
        aw_valid = 1'b1; aw_addr = 64'h300; aw_len = 8'd0;
        ar_valid = 1'b1; ar_addr = 64'h8000_0100; ar_len = 8'd0;
        @(negedge clock);
        chk("both_aw_ready", {63'd0, aw_ready}, 64'd1);
        chk("both_ar_ready", {63'd0, ar_ready}, 64'd0);
        @(posedge clock); #1;
        aw_valid = 1'b0;
        w_beat(64'h5555_6666_7777_8888, 8'hF0, 1'b1);
        for (int t = 0; t < 50; t++) begin
            @(negedge clock);
            if (ar_ready) break;
            if (t == 49) stray("ar_after_b_timeout");
        end
        @(posedge clock); #1;
        ar_valid = 1'b0;
        drain(50);
        chk("ar_after_b", {63'd0, ar_hs_cyc > b_hs_cyc}, 64'd1);

        // address wrap at the top of the address space
        exp_read(64'hFFFF_FFFF_FFFF_FFF8, 1);
        ar_req(64'hFFFF_FFFF_FFFF_FFFF, 8'd1);
        drain(50);

        // maximum burst length
        exp_read(64'h1000, 255);
        ar_req(64'h1000, 8'd255);
        drain(1000);

        // reset in the middle of a 4-beat read
        r_ready = 1'b0;
        exp_read(64'h8000_0080, 3);
        ar_req(64'h8000_0080, 8'd3);
        wait_rvalid();
        @(posedge clock); #1;
        reset = 1'b0;
        rq.delete(); raddr_q.delete();
        #1;
        chk("rst_mid_r_valid", {63'd0, r_valid}, 64'd0);
        chk("rst_mid_mem_en", {63'd0, mem_en}, 64'd0);
        chk("rst_mid_r_last", {63'd0, r_last}, 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        r_ready = 1'b1;
        repeat (10) @(posedge clock);
        @(negedge clock);
        chk("post_rst_ar_ready", {63'd0, ar_ready}, 64'd1);
        chk("post_rst_r_valid", {63'd0, r_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
